// File: rtl/key_press_counter_pkg.sv
// key_pkg: shared constants for the pushbutton input path.
//   CLK_HZ          - system clock frequency (CLOCK_50)
//   DEBOUNCE_MS     - debounce window in milliseconds
//   DEBOUNCE_CYCLES - default debounce length in clock cycles, derived from the two above
//   SYNC_STAGES     - depth of the metastability synchronizer on raw pins
//   dir_e           - count direction as seen on the 'up' input
package key_pkg;

    localparam int CLK_HZ          = 50_000_000;
    localparam int DEBOUNCE_MS     = 20;
    localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int SYNC_STAGES     = 2;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/key_press_counter_if.sv
// key_press_counter_if: bundles the button input, counter controls and the
// debounced outputs of key_press_counter.
//   KEY_N   - raw pushbutton, active-low, asynchronous to CLOCK_50
//   enable  - count enable
//   up      - count direction (1 = increment, 0 = decrement)
//   pressed - debounced button level, 1 = held
//   press   - one-cycle pulse per accepted press
//   count   - WIDTH-bit press count
// The master modport drives the inputs (board top / bench); the slave modport
// is the counter itself.
interface key_press_counter_if #(
    parameter int WIDTH = 10
);
    logic             KEY_N;
    logic             enable;
    logic             up;
    logic             pressed;
    logic             press;
    logic [WIDTH-1:0] count;

    modport master (
        output KEY_N,
        output enable,
        output up,
        input  pressed,
        input  press,
        input  count
    );

    modport slave (
        input  KEY_N,
        input  enable,
        input  up,
        output pressed,
        output press,
        output count
    );
endinterface

// File: rtl/key_press_counter_debounce.sv
// debounce: synchronizes one raw asynchronous input and debounces it.
//   CLOCK_50 - system clock, all state updates on the rising edge
//   reset    - synchronous active-high reset (synchronizer loads "released")
//   din      - raw input pin (active-low when ACTIVE_LOW = 1)
//   dout     - debounced active-high level (registered)
//   rise     - combinational flag: dout will go 0->1 on the coming edge.
//              Intended to be registered by the parent so its pulse lines
//              up with dout.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive
// synchronized samples that all differ from the current dout.
module debounce #(
    parameter int DEBOUNCE_CYCLES = key_pkg::DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);
    import key_pkg::*;

    localparam int             CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  DCNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Synchronizer chain; stage 0 samples the pin, the last stage feeds the debouncer.
    logic sync_reg [SYNC_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge CLOCK_50) begin
                    if (reset) sync_reg[gi] <= ACTIVE_LOW;
                    else       sync_reg[gi] <= din;
                end
            end else begin : g_next
                always_ff @(posedge CLOCK_50) begin
                    if (reset) sync_reg[gi] <= ACTIVE_LOW;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // Active-high synchronized sample.
    logic sample;
    assign sample = sync_reg[SYNC_STAGES-1] ^ ACTIVE_LOW;

    logic          stable_reg, stable_next;
    logic [CW-1:0] dcnt_reg,   dcnt_next;

    always_comb begin
        stable_next = stable_reg;
        dcnt_next   = '0;
        if (sample != stable_reg) begin
            if (dcnt_reg == DCNT_LAST) begin
                stable_next = sample;
            end else begin
                dcnt_next = dcnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            stable_reg <= 1'b0;
            dcnt_reg   <= '0;
        end else begin
            stable_reg <= stable_next;
            dcnt_reg   <= dcnt_next;
        end
    end

    assign dout = stable_reg;
    assign rise = stable_next & ~stable_reg;

endmodule

// File: rtl/key_press_counter.sv
// key_press_counter: clean press events and a press count from one raw
// DE-series pushbutton, all in the CLOCK_50 domain.
//   CLOCK_50 - 50 MHz system clock
//   reset    - synchronous active-high reset, overrides everything
//   bus      - key_press_counter_if slave: KEY_N/enable/up in,
//              pressed/press/count out (all outputs registered)
// press fires in the same cycle pressed first reads 1; count moves one
// cycle after press, so the count never changes by more than 1 per cycle.
module key_press_counter #(
    parameter int DEBOUNCE_CYCLES = key_pkg::DEBOUNCE_CYCLES,
    parameter int WIDTH           = 10
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    key_press_counter_if.slave  bus
);
    import key_pkg::*;

    logic pressed;
    logic rise;

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (1'b1)
    ) u_debounce (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .din      (bus.KEY_N),
        .dout     (pressed),
        .rise     (rise)
    );

    // Registering the debouncer's "about to rise" flag aligns press with pressed.
    logic press_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) press_reg <= 1'b0;
        else       press_reg <= rise;
    end

    logic [WIDTH-1:0] count_reg, count_next;

    always_comb begin
        count_next = count_reg;
        if (press_reg && bus.enable) begin
            if (dir_e'(bus.up) == DIR_UP) count_next = count_reg + WIDTH'(1);
            else                          count_next = count_reg - WIDTH'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) count_reg <= '0;
        else       count_reg <= count_next;
    end

    assign bus.pressed = pressed;
    assign bus.press   = press_reg;
    assign bus.count   = count_reg;

endmodule

// File: tb/tb_key_press_counter.sv
// Bench for key_press_counter with DEBOUNCE_CYCLES=4, WIDTH=4: directed
// scenarios followed by randomized button activity, every cycle compared
// against a behavioural model built from the debounce rules.
module tb_key_press_counter;

    localparam int DC   = 4;
    localparam int W    = 4;
    localparam int MODV = 1 << W;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    key_press_counter_if #(.WIDTH(W)) ifc ();

    key_press_counter #(
        .DEBOUNCE_CYCLES (DC),
        .WIDTH           (W)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (ifc)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pulses   = 0;

    // Reference model state.
    bit dq[$];          // raw KEY_N samples still travelling through the synchronizer
    bit m_pressed = 1'b0;
    bit m_press   = 1'b0;
    int m_run     = 0;  // consecutive debouncer samples that disagree with m_pressed
    int m_count   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        else
            n_pass++;
    endtask

    // One rising edge of the model, applied with the inputs that edge sees.
    task automatic model_edge(input bit k, input bit e, input bit u, input bit r);
        bit old_key;
        bit s;
        if (r) begin
            dq        = '{1'b1, 1'b1};
            m_pressed = 1'b0;
            m_press   = 1'b0;
            m_run     = 0;
            m_count   = 0;
        end else begin
            old_key = dq.pop_front();
            dq.push_back(k);
            s = ~old_key;
            if (m_press && e)
                m_count = u ? (m_count + 1) % MODV : (m_count + MODV - 1) % MODV;
            m_press = 1'b0;
            if (s != m_pressed) begin
                m_run++;
                if (m_run == DC) begin
                    m_pressed = s;
                    m_press   = s;
                    m_run     = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic step(input bit k, input bit e, input bit u, input bit r);
        ifc.KEY_N  = k;
        ifc.enable = e;
        ifc.up     = u;
        reset      = r;
        @(posedge clk);
        model_edge(k, e, u, r);
        #1;
        cyc++;
        check("pressed", 32'(ifc.pressed), 32'(m_pressed));
        check("press",   32'(ifc.press),   32'(m_press));
        check("count",   32'(ifc.count),   32'(m_count));
        if (ifc.press === 1'b1) pulses++;
        if (m_press) $display("cycle %0d: press accepted, enable=%0b up=%0b count=%0d", cyc, e, u, m_count);
    endtask

    task automatic full_press(input bit e, input bit u);
        repeat (8) step(1'b0, e, u, 1'b0);
        repeat (8) step(1'b1, e, u, 1'b0);
    endtask

    initial begin
        dq = '{1'b1, 1'b1};
        ifc.KEY_N  = 1'b1;
        ifc.enable = 1'b1;
        ifc.up     = 1'b1;

        // Reset held with the button down, then refill + debounce.
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("rst_count", 32'(ifc.count), 32'd0);
        check("rst_press", 32'(ifc.press), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (i == 5) check("rst_pressed_e5", 32'(ifc.pressed), 32'd0);
            if (i == 6) check("rst_pressed_e6", 32'(ifc.pressed), 32'd1);
        end
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1);

        // Clean press, i = 0 is edge k.
        pulses = 0;
        for (int i = 0; i <= 6; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (i == 4) check("clean_pressed_k4", 32'(ifc.pressed), 32'd0);
            if (i == 5) begin
                check("clean_pressed_k5", 32'(ifc.pressed), 32'd1);
                check("clean_press_k5",   32'(ifc.press),   32'd1);
            end
            if (i == 6) begin
                check("clean_press_k6", 32'(ifc.press), 32'd0);
                check("clean_count_k6", 32'(ifc.count), 32'd1);
            end
        end
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("clean_pulses", 32'(pulses), 32'd1);
        check("clean_release_count", 32'(ifc.count), 32'd1);

        // Bounce: never stable long enough.
        pulses = 0;
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("bounce_pulses", 32'(pulses), 32'd0);
        check("bounce_count",  32'(ifc.count), 32'd1);

        // Wrap up and down.
        repeat (14) full_press(1'b1, 1'b1);
        check("wrap_pre", 32'(ifc.count), 32'd15);
        full_press(1'b1, 1'b1);
        check("wrap_up", 32'(ifc.count), 32'd0);
        full_press(1'b1, 1'b0);
        check("wrap_down", 32'(ifc.count), 32'd15);

        // Enable gating.
        pulses = 0;
        repeat (2) full_press(1'b0, 1'b1);
        check("gate_pulses", 32'(pulses), 32'd2);
        check("gate_count",  32'(ifc.count), 32'd15);
        full_press(1'b1, 1'b1);
        check("gate_en_count", 32'(ifc.count), 32'd0);

        // Reset at the second mismatching debouncer sample.
        full_press(1'b1, 1'b1);
        pulses = 0;
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
        check("middeb_rst_pulses", 32'(pulses), 32'd0);
        check("middeb_rst_count",  32'(ifc.count), 32'd0);
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0);
        check("middeb_pulses", 32'(pulses), 32'd1);
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0);
        check("middeb_count", 32'(ifc.count), 32'd1);

        // Randomized button activity with occasional resets.
        for (int n = 0; n < 150; n++) begin
            int unsigned len;
            bit k, e, u, r;
            len = $urandom_range(1, 10);
            k   = 1'($urandom_range(0, 1));
            e   = ($urandom_range(0, 3) != 0);
            u   = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 29) == 0);
            for (int j = 0; j < int'(len); j++)
                step(k, e, u, r && (j == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
